// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first for 'reps' frames.
// Define SEQ_TX_GAP_EN to insert GAP idle cycles between consecutive frames.
module seq_pattern_tx #(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [3:0]       reps,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef SEQ_TX_GAP_EN
        S_GAP  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       reps_q, reps_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       frame_q, frame_d;
    logic             dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SEQ_TX_GAP_EN
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    logic [3:0]       gap_q, gap_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        reps_d  = reps_q;
        bit_d   = bit_q;
        frame_d = frame_q;
`ifdef SEQ_TX_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (reps != 4'd0) begin
                        pat_d   = pat_in;
                        reps_d  = reps;
                        shreg_d = pat_in;
                        bit_d   = '0;
                        frame_d = '0;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_q == LAST_BIT) begin
                    frame_d = frame_q + 4'd1;
                    bit_d   = '0;
                    if (frame_d == reps_q) begin
                        state_d = S_DONE;
                    end else begin
`ifdef SEQ_TX_GAP_EN
                        gap_d   = '0;
                        state_d = S_GAP;
`else
                        shreg_d = pat_q;
`endif
                    end
                end else begin
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + 1'b1;
                end
            end
`ifdef SEQ_TX_GAP_EN
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    shreg_d = pat_q;
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        dvalid_d = (state_d == S_SEND);
        dout_d   = dvalid_d & shreg_d[PAT_W-1];
`ifdef SEQ_TX_GAP_EN
        busy_d   = (state_d == S_SEND) || (state_d == S_GAP);
`else
        busy_d   = (state_d == S_SEND);
`endif
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            pat_q    <= '0;
            reps_q   <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_TX_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            pat_q    <= pat_d;
            reps_q   <= reps_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_TX_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the bit-serial `din` input of the sequence-detector family, for example the Moore 10110 overlap detector. On a start request it latches a PAT_W-bit pattern and a repeat count, then shifts the pattern out MSB-first, one bit per clock, for the requested number of frames. It is the producer side of the serial-pattern link and serves as a synthesizable stimulus source for detector bring-up.

## Interface
Parameters:
- `PAT_W`, default 5: pattern length in bits, legal range 2..16.
- `GAP`, default 2: number of idle cycles between frames. Used only when SEQ_TX_GAP_EN is defined; legal range 1..15.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: transmit request. Sampled only in IDLE.
- `abort`, input, 1: cancels transmission; the block returns to IDLE.
- `pat_in`, input, PAT_W: pattern to send, MSB first. Latched on an accepted start.
- `reps`, input, 4: number of frames to send, 0..15. Latched on an accepted start.
- `dout`, output, 1: serial data bit. Forced to 0 whenever `dvalid` is 0.
- `dvalid`, output, 1: high while `dout` carries a pattern bit.
- `busy`, output, 1: high in SEND and GAP.
- `done`, output, 1: one-cycle pulse on normal completion.

## Operation
- Reset (`rst`=1 at an edge): state goes to IDLE; `dout`, `dvalid`, `busy` and `done` are all 0; shift register, bit counter and frame counter are cleared. Reset has priority over every other input, including mid-frame.
- IDLE:
  - `start`=1, `abort`=0, `reps`≠0: latch `pat_in` and `reps`, load the shift register, go to SEND.
  - `start`=1 with `reps`=0: nothing is transmitted; go to DONE.
  - `start` and `abort` both 1: `abort` wins; stay in IDLE.
- SEND:
  - `dout` = shift-register MSB; `dvalid`=1.
  - Each cycle the register shifts left by one and the bit counter increments.
  - After bit PAT_W-1, the frame counter increments.
  - If frames sent equals `reps`, go to DONE.
  - Otherwise go to GAP (macro defined) or reload the latched pattern and stay in SEND (macro undefined).
- GAP: `dout`=0, `dvalid`=0, `busy`=1 for exactly GAP cycles, then reload the pattern and go to SEND.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- `abort`=1 in SEND or GAP: go to IDLE at that edge. `done` does not pulse and the partial frame is truncated.
- `start` outside IDLE is ignored. `pat_in` and `reps` are don't-care except in the cycle a start is accepted.
- Counter widths: the bit counter is sized by $clog2(PAT_W); the frame counter is 4 bits and cannot wrap because `reps` ≤ 15.

## Timing
- If start is accepted at edge N, the first bit is valid in the cycle after N.
- One frame lasts PAT_W cycles.
- Total `busy` cycles = reps·PAT_W, plus (reps-1)·GAP when the macro is defined.
- `done` asserts in the cycle immediately after the last data bit.
- A new start is accepted at the earliest in the cycle after `done`, since the block is back in IDLE by then.
- All outputs are registered; none has a combinational path from an input.

## Configuration
- `SEQ_TX_GAP_EN` defined: GAP idle cycles are inserted between consecutive frames. No gap follows the final frame.
- `SEQ_TX_GAP_EN` undefined: frames are sent back to back. The GAP state and its counter are not built, and the `GAP` parameter is ignored.

## Test plan
1. Reset, then start with pat_in=5'b10110, reps=1 -> dout=1,0,1,1,0 on five consecutive valid cycles, then `done` for 1 cycle, then `busy`=0. Feed `dout` into the 10110 detector -> detector reports exactly one detection.
2. No macro, pat_in=10110, reps=3 -> an uninterrupted 15-bit stream 101101011010110 with `dvalid` held high for 15 cycles and `done` at cycle 16.
3. `SEQ_TX_GAP_EN` with GAP=2, reps=2 -> 10110, then 2 cycles with dvalid=0/dout=0, then 10110, then `done`. Total `busy` = 12 cycles.
4. start with reps=0 -> `dvalid` never asserts; `done` pulses in the cycle after start.
5. Assert `abort` on the 3rd bit of the 2nd frame -> IDLE at the next edge, dvalid=0, no `done`. A following start with pat_in=11001 sends 11001 correctly.
6. Assert `rst` mid-frame -> all outputs 0 at the next edge. Assert `start` during `busy` -> ignored, the stream continues unchanged. Assert `start` and `abort` together in IDLE -> no transmission.
